simd_add_scheduler: RTL and testbench

Round-robin arbiter and sequencer that shares one `dsp_simd4x_int12_add` 4-lane INT12 SIMD adder between `NUM_REQ` requesters. Each requester presents one 48-bit packed operand pair per transaction with a valid/ready handshake. The block issues at most one transaction per enabled cycle and tags it through a pipeline matching the adder latency. Each result is returned to the originating requester, and response backpressure stalls the shared adder through its clock enable. It sits between the bicubic interpolation lanes and the adder instance.

---
 rtl/simd_add_scheduler.sv | 132 +++++++++++++
 tb/tb_simd_add_scheduler.sv | 322 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/simd_add_scheduler.sv
// simd_add_scheduler
//   Shares one 4-lane INT12 SIMD adder between NUM_REQ requesters.
//   A round-robin arbiter issues at most one operand pair per enabled
//   cycle. A tag pipeline as deep as the adder latency carries the
//   requester id alongside the adder's internal registers. Each result
//   is returned on a shared bus with a per-requester valid. Response
//   backpressure stalls the adder, the tags and the arbiter through
//   add_clken.
//
// Ports
//   clk, areset          : clock, asynchronous active-high reset
//   flush                : synchronous flush of all in-flight work
//   req_valid/req_ready  : per-requester request handshake
//   req_a/req_b          : per-requester 48-bit operands {x3,x2,x1,x0}
//   rsp_valid/rsp_ready  : per-requester response handshake
//   rsp_data             : shared result bus (adder sum, passed through)
//   add_clken            : adder clock enable
//   add_dsp_reset        : adder synchronous reset
//   add_a/add_b          : adder operands
//   add_sum              : adder result
//   busy                 : at least one transaction in flight
module simd_add_scheduler #(
  parameter int unsigned NUM_REQ     = 4,
  parameter int unsigned ADD_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  areset,
  input  logic                  flush,
  input  logic [NUM_REQ-1:0]    req_valid,
  output logic [NUM_REQ-1:0]    req_ready,
  input  logic [NUM_REQ*48-1:0] req_a,
  input  logic [NUM_REQ*48-1:0] req_b,
  output logic [NUM_REQ-1:0]    rsp_valid,
  input  logic [NUM_REQ-1:0]    rsp_ready,
  output logic [47:0]           rsp_data,
  output logic                  add_clken,
  output logic                  add_dsp_reset,
  output logic [47:0]           add_a,
  output logic [47:0]           add_b,
  input  logic [47:0]           add_sum,
  output logic                  busy
);

  localparam int unsigned IDW = $clog2(NUM_REQ);

  logic [ADD_LATENCY-1:0]          vld_q, vld_d;
  logic [ADD_LATENCY-1:0][IDW-1:0] id_q, id_d;
  logic [IDW-1:0]                  ptr_q, ptr_d;
  logic                            rst_hold_q, rst_hold_d;

  logic           grant_any;
  logic [IDW-1:0] grant_id;
  logic [IDW-1:0] cand;
  logic           accept;
  logic           last_vld;
  logic [IDW-1:0] last_id;

  assign last_vld = vld_q[ADD_LATENCY-1];
  assign last_id  = id_q[ADD_LATENCY-1];

  // Flush overrides a pending stall so the discarded tags can drain.
  assign add_clken     = !(last_vld && !rsp_ready[last_id]) || flush;
  assign add_dsp_reset = flush | rst_hold_q;
  assign rsp_data      = add_sum;
  assign busy          = |vld_q;
  assign accept        = grant_any && add_clken && !flush;

  // Round-robin search: first valid index at or after ptr, circularly.
  always_comb begin
    grant_any = 1'b0;
    grant_id  = '0;
    cand      = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = IDW'((32'(ptr_q) + k) % NUM_REQ);
      if (!grant_any && req_valid[cand]) begin
        grant_any = 1'b1;
        grant_id  = cand;
      end
    end
    if (rst_hold_q) grant_any = 1'b0;
  end

  always_comb begin
    req_ready = '0;
    rsp_valid = '0;
    add_a     = '0;
    add_b     = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (accept && grant_id == IDW'(i)) begin
        req_ready[i] = 1'b1;
        add_a        = req_a[48*i +: 48];
        add_b        = req_b[48*i +: 48];
      end
      rsp_valid[i] = last_vld && (last_id == IDW'(i));
    end
  end

  always_comb begin
    vld_d      = vld_q;
    id_d       = id_q;
    ptr_d      = ptr_q;
    rst_hold_d = 1'b0;
    if (flush) begin
      vld_d = '0;
    end else if (add_clken) begin
      for (int unsigned s = ADD_LATENCY - 1; s > 0; s--) begin
        vld_d[s] = vld_q[s-1];
        id_d[s]  = id_q[s-1];
      end
      vld_d[0] = accept;
      id_d[0]  = grant_id;
    end
    if (accept) begin
      ptr_d = (grant_id == IDW'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      vld_q      <= '0;
      id_q       <= '0;
      ptr_q      <= '0;
      rst_hold_q <= 1'b1;
    end else begin
      vld_q      <= vld_d;
      id_q       <= id_d;
      ptr_q      <= ptr_d;
      rst_hold_q <= rst_hold_d;
    end
  end

endmodule

// File: tb/tb_simd_add_scheduler.sv
`timescale 1ns/1ps
module tb_simd_add_scheduler;

  localparam int unsigned NR  = 4;
  localparam int unsigned LAT = 2;

  logic              clk = 1'b0;
  logic              areset;
  logic              flush;
  logic [NR-1:0]     req_valid;
  logic [NR-1:0]     req_ready;
  logic [NR*48-1:0]  req_a;
  logic [NR*48-1:0]  req_b;
  logic [NR-1:0]     rsp_valid;
  logic [NR-1:0]     rsp_ready;
  logic [47:0]       rsp_data;
  logic              add_clken;
  logic              add_dsp_reset;
  logic [47:0]       add_a;
  logic [47:0]       add_b;
  logic [47:0]       add_sum;
  logic              busy;

  simd_add_scheduler #(.NUM_REQ(NR), .ADD_LATENCY(LAT)) dut (
    .clk(clk), .areset(areset), .flush(flush),
    .req_valid(req_valid), .req_ready(req_ready), .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .add_clken(add_clken), .add_dsp_reset(add_dsp_reset),
    .add_a(add_a), .add_b(add_b), .add_sum(add_sum), .busy(busy)
  );

  always #5 clk = ~clk;

  // Two-stage lane-wise adder standing in for the DSP instance.
  logic [47:0] s1_q, p_q;
  always @(posedge clk) begin
    if (add_dsp_reset) begin
      s1_q <= '0;
      p_q  <= '0;
    end else if (add_clken) begin
      for (int k = 0; k < 4; k++) s1_q[12*k +: 12] <= add_a[12*k +: 12] + add_b[12*k +: 12];
      p_q <= s1_q;
    end
  end
  assign add_sum = p_q;

  typedef struct { int unsigned id; logic [47:0] a; logic [47:0] b; logic [47:0] e; } vec_t;
  typedef struct { int unsigned id; logic [47:0] data; } sb_t;
  typedef struct { int unsigned id; int unsigned cyc; } ev_t;

  vec_t pend_q[$];
  sb_t  sb_q[$];
  ev_t  grant_log[$];
  ev_t  rsp_log[$];

  int          n_checks = 0;
  int          n_fail   = 0;
  int unsigned cyc      = 0;

  logic [NR-1:0] s_req_ready, s_rsp_valid;
  logic [47:0]   s_rsp_data;
  logic          s_clken, s_dsp_reset, s_busy;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push_req(input int unsigned id, input logic [47:0] a,
                          input logic [47:0] b, input logic [47:0] e);
    vec_t v;
    v.id = id; v.a = a; v.b = b; v.e = e;
    pend_q.push_back(v);
  endtask

  // One clock cycle: drive pending requests, sample at negedge, retire accepts.
  task automatic step();
    logic [NR-1:0] v;
    int unsigned   slot [NR];
    int unsigned   id;
    int            del;
    sb_t           s;
    ev_t           g;
    v = '0; req_a = '0; req_b = '0; del = -1;
    for (int i = 0; i < NR; i++) slot[i] = 0;
    for (int j = 0; j < pend_q.size(); j++) begin
      id = pend_q[j].id;
      if (!v[id]) begin
        v[id] = 1'b1;
        slot[id] = j;
        req_a[48*id +: 48] = pend_q[j].a;
        req_b[48*id +: 48] = pend_q[j].b;
      end
    end
    req_valid = v;
    @(negedge clk);
    s_req_ready = req_ready; s_rsp_valid = rsp_valid; s_rsp_data = rsp_data;
    s_clken = add_clken; s_dsp_reset = add_dsp_reset; s_busy = busy;
    chk("ready_without_valid", 64'(req_ready & ~req_valid), 0);
    for (int i = 0; i < NR; i++) begin
      if (req_ready[i] && req_valid[i]) begin
        s.id = i; s.data = pend_q[slot[i]].e;
        sb_q.push_back(s);
        g.id = i; g.cyc = cyc;
        grant_log.push_back(g);
        del = int'(slot[i]);
      end
    end
    if (del >= 0) pend_q.delete(del);
    @(posedge clk); #1;
  endtask

  // Monitor: every completed response transfer is matched against the scoreboard.
  int unsigned mon_rid;
  sb_t         mon_e;
  ev_t         mon_ev;
  always @(negedge clk) begin
    if (!areset && rsp_valid != '0) begin
      chk("rsp_onehot", 64'($onehot(rsp_valid)), 1);
      if ((rsp_valid & rsp_ready) != '0) begin
        mon_rid = 0;
        for (int i = 0; i < NR; i++) if (rsp_valid[i]) mon_rid = i;
        if (sb_q.size() == 0) begin
          chk("rsp_unexpected", 64'(rsp_valid), 0);
        end else begin
          mon_e = sb_q.pop_front();
          chk("rsp_id", 64'(mon_rid), 64'(mon_e.id));
          chk("rsp_data", 64'(rsp_data), 64'(mon_e.data));
        end
        mon_ev.id = mon_rid; mon_ev.cyc = cyc;
        rsp_log.push_back(mon_ev);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  int unsigned g0, r0;

  initial begin
    areset = 1'b1; flush = 1'b0; rsp_ready = '1;
    req_valid = '0; req_a = '0; req_b = '0;

    // Reset values
    @(negedge clk);
    chk("rst_req_ready", 64'(req_ready), 0);
    chk("rst_rsp_valid", 64'(rsp_valid), 0);
    chk("rst_busy", 64'(busy), 0);
    chk("rst_add_a", 64'(add_a), 0);
    chk("rst_add_b", 64'(add_b), 0);
    chk("rst_dsp_reset", 64'(add_dsp_reset), 1);
    chk("rst_clken", 64'(add_clken), 1);
    @(posedge clk); #1;
    areset = 1'b0;
    push_req(0, 48'h001_001_001_001, 48'h001_001_001_001, 48'h002_002_002_002);
    step();
    chk("hold_dsp_reset", 64'(s_dsp_reset), 1);
    chk("hold_no_grant", 64'(s_req_ready), 0);
    step();
    chk("hold_released", 64'(s_dsp_reset), 0);
    chk("first_grant_0", 64'(s_req_ready), 4'b0001);
    repeat (3) step();

    // Single request from requester 1 (ptr now 1)
    push_req(1, {12'd4, 12'd3, 12'd2, 12'd1}, {12'd40, 12'd30, 12'd20, 12'd10},
                {12'd44, 12'd33, 12'd22, 12'd11});
    step();
    chk("single_ready", 64'(s_req_ready), 4'b0010);
    step();
    chk("single_rsp_early", 64'(s_rsp_valid), 0);
    step();
    chk("single_rsp_valid", 64'(s_rsp_valid), 4'b0010);
    chk("single_rsp_data", 64'(s_rsp_data), {12'd44, 12'd33, 12'd22, 12'd11});

    // Lane wrap from requester 3
    push_req(3, {12'h800, 12'd5, 12'd6, 12'h7FF}, {12'hFFF, 12'd7, 12'd8, 12'd1},
                {12'h7FF, 12'h00C, 12'h00E, 12'h800});
    step();
    chk("wrap_ready", 64'(s_req_ready), 4'b1000);
    step(); step();
    chk("wrap_rsp_valid", 64'(s_rsp_valid), 4'b1000);
    chk("wrap_rsp_data", 64'(s_rsp_data), {12'h7FF, 12'h00C, 12'h00E, 12'h800});

    // Round robin, all four holding valid (ptr now 0)
    g0 = grant_log.size(); r0 = rsp_log.size();
    push_req(0, {12'd100, 12'd200, 12'd300, 12'd400}, {12'd1, 12'd2, 12'd3, 12'd4}, {12'd101, 12'd202, 12'd303, 12'd404});
    push_req(1, 48'h111_222_333_444, 48'h111_222_333_444, 48'h222_444_666_888);
    push_req(2, 48'hFFF_FFF_FFF_FFF, 48'h001_002_003_004, 48'h000_001_002_003);
    push_req(3, 48'h123_456_789_ABC, 48'h010_020_030_040, 48'h133_476_7B9_AFC);
    push_req(0, 48'h000_000_000_000, 48'hA5A_5A5_0F0_F0F, 48'hA5A_5A5_0F0_F0F);
    push_req(1, 48'h800_800_800_800, 48'h800_800_800_800, 48'h000_000_000_000);
    push_req(2, 48'h001_010_100_400, 48'h001_010_100_C00, 48'h002_020_200_000);
    push_req(3, 48'h7FF_7FF_7FF_7FF, 48'h7FF_7FF_7FF_7FF, 48'hFFE_FFE_FFE_FFE);
    repeat (10) step();
    chk("rr_grant_count", 64'(grant_log.size() - g0), 8);
    chk("rr_rsp_count", 64'(rsp_log.size() - r0), 8);
    for (int k = 0; k < 8; k++) begin
      if (g0 + k < grant_log.size() && r0 + k < rsp_log.size()) begin
        chk("rr_grant_order", 64'(grant_log[g0+k].id), 64'(k % 4));
        chk("rr_grant_cycle", 64'(grant_log[g0+k].cyc), 64'(grant_log[g0].cyc + k));
        chk("rr_rsp_order", 64'(rsp_log[r0+k].id), 64'(k % 4));
        chk("rr_rsp_cycle", 64'(rsp_log[r0+k].cyc), 64'(grant_log[g0+k].cyc + 2));
      end
    end

    // Backpressure on requester 2 (ptr now 0)
    rsp_ready = 4'b1011;
    push_req(2, {12'd1, 12'd1, 12'd1, 12'd1}, {12'd2, 12'd3, 12'd4, 12'd5}, {12'd3, 12'd4, 12'd5, 12'd6});
    push_req(3, 48'h00A_00B_00C_00D, 48'h100_200_300_400, 48'h10A_20B_30C_40D);
    step();
    chk("bp_grant2", 64'(s_req_ready), 4'b0100);
    push_req(0, {12'hFFE, 12'd0, 12'd0, 12'd7}, {12'd3, 12'd0, 12'd0, 12'd9}, 48'h001_000_000_010);
    step();
    chk("bp_grant3", 64'(s_req_ready), 4'b1000);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("bp_clken_low", 64'(s_clken), 0);
      chk("bp_no_ready", 64'(s_req_ready), 0);
      chk("bp_rsp_valid", 64'(s_rsp_valid), 4'b0100);
      chk("bp_rsp_stable", 64'(s_rsp_data), {12'd3, 12'd4, 12'd5, 12'd6});
    end
    rsp_ready = '1;
    r0 = rsp_log.size();
    step();
    chk("bp_release_grant0", 64'(s_req_ready), 4'b0001);
    chk("bp_release_rsp", 64'(s_rsp_valid), 4'b0100);
    step();
    chk("bp_next_rsp", 64'(s_rsp_valid), 4'b1000);
    step();
    chk("bp_third_rsp", 64'(s_rsp_valid), 4'b0001);
    chk("bp_rsp_count", 64'(rsp_log.size() - r0), 3);
    if (rsp_log.size() >= r0 + 3) begin
      chk("bp_order_a", 64'(rsp_log[r0].id), 2);
      chk("bp_order_b", 64'(rsp_log[r0+1].id), 3);
      chk("bp_next_cycle", 64'(rsp_log[r0+1].cyc), 64'(rsp_log[r0].cyc + 1));
    end

    // Flush with two in flight (ptr now 1)
    push_req(1, 48'h009_009_009_009, 48'h009_009_009_009, 48'h012_012_012_012);
    push_req(2, 48'h0F0_0F0_0F0_0F0, 48'h001_001_001_001, 48'h0F1_0F1_0F1_0F1);
    step();
    chk("fl_grant1", 64'(s_req_ready), 4'b0010);
    step();
    chk("fl_grant2", 64'(s_req_ready), 4'b0100);
    push_req(3, 48'h321_654_987_CBA, 48'h001_001_001_001, 48'h322_655_988_CBB);
    rsp_ready = '0; flush = 1'b1;
    step();
    chk("fl_dsp_reset", 64'(s_dsp_reset), 1);
    chk("fl_clken", 64'(s_clken), 1);
    chk("fl_no_ready", 64'(s_req_ready), 0);
    flush = 1'b0; rsp_ready = '1;
    sb_q.delete();
    r0 = rsp_log.size();
    step();
    chk("fl_busy_cleared", 64'(s_busy), 0);
    chk("fl_no_rsp", 64'(s_rsp_valid), 0);
    chk("fl_dsp_reset_1cyc", 64'(s_dsp_reset), 0);
    chk("fl_grant3", 64'(s_req_ready), 4'b1000);
    step();
    chk("fl_rsp_early", 64'(s_rsp_valid), 0);
    step();
    chk("fl_rsp_valid", 64'(s_rsp_valid), 4'b1000);
    chk("fl_rsp_data", 64'(s_rsp_data), 48'h322_655_988_CBB);
    step();
    chk("fl_idle", 64'(s_busy), 0);
    chk("fl_rsp_count", 64'(rsp_log.size() - r0), 1);

    // Asynchronous reset mid-stream (ptr now 0)
    push_req(1, 48'h001_001_001_001, 48'h001_001_001_001, 48'h002_002_002_002);
    push_req(2, 48'h000_000_000_000, 48'h000_000_000_000, 48'h000_000_000_000);
    push_req(3, 48'h100_200_300_400, 48'h011_022_033_044, 48'h111_222_333_444);
    step();
    chk("ar_grant1", 64'(s_req_ready), 4'b0010);
    step();
    chk("ar_grant2", 64'(s_req_ready), 4'b0100);
    #2 areset = 1'b1;
    #1;
    chk("ar_req_ready", 64'(req_ready), 0);
    chk("ar_rsp_valid", 64'(rsp_valid), 0);
    chk("ar_busy", 64'(busy), 0);
    chk("ar_add_a", 64'(add_a), 0);
    chk("ar_add_b", 64'(add_b), 0);
    chk("ar_dsp_reset", 64'(add_dsp_reset), 1);
    chk("ar_clken", 64'(add_clken), 1);
    sb_q.delete();
    push_req(0, 48'hFFF_000_FFF_000, 48'h001_001_001_001, 48'h000_001_000_001);
    @(posedge clk); #1;
    areset = 1'b0;
    r0 = rsp_log.size();
    step();
    chk("ar_hold_dsp_reset", 64'(s_dsp_reset), 1);
    chk("ar_hold_no_grant", 64'(s_req_ready), 0);
    step();
    chk("ar_hold_released", 64'(s_dsp_reset), 0);
    chk("ar_first_grant0", 64'(s_req_ready), 4'b0001);
    step();
    chk("ar_then_grant3", 64'(s_req_ready), 4'b1000);
    step();
    chk("ar_rsp0", 64'(s_rsp_valid), 4'b0001);
    step();
    chk("ar_rsp3", 64'(s_rsp_valid), 4'b1000);
    step();
    chk("ar_idle", 64'(s_busy), 0);
    chk("ar_rsp_count", 64'(rsp_log.size() - r0), 2);

    chk("sb_drained", 64'(sb_q.size()), 0);
    chk("pend_drained", 64'(pend_q.size()), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
